// File: rtl/full_adder_bist_pkg.sv
// Shared types and golden model for the full-adder built-in self-test.
// Holds the FSM state encoding, the vector count and the reference adder.
package full_adder_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int NUM_VECTORS = 8;

  // Returns {carry, sum}.
  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder, the cell exercised by full_adder_bist.
// Zero latency; no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/full_adder_selftest.sv
// Pairs full_adder_bist with one full_adder instance for in-silicon self-test.
// Latency and start handling are those of full_adder_bist.
module full_adder_selftest #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_vec,
  output logic [3:0] err_count
);

  logic fa_a, fa_b, fa_c, fa_sum, fa_carry;

  full_adder u_fa (
    .a     (fa_a),
    .b     (fa_b),
    .c     (fa_c),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  full_adder_bist #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CONTINUOUS    (CONTINUOUS)
  ) u_bist (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_out     (fa_a),
    .b_out     (fa_b),
    .c_out     (fa_c),
    .sum_in    (fa_sum),
    .carry_in  (fa_carry),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec),
    .err_count (err_count)
  );

endmodule

// File: rtl/full_adder_bist.sv
// On-chip stimulus generator and checker for one full_adder: 8 vectors, golden compare.
// Latency: done SETTLE_CYCLES*8+18 cycles after start; start ignored while a run is active.
module full_adder_bist
  import full_adder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       sum_in,
  input  logic       carry_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_vec,
  output logic [3:0] err_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] fail_q, fail_d;
  logic [3:0] err_q, err_d;

  logic [1:0] gold;
  logic       mism;
  logic [7:0] fail_base;
  logic [3:0] err_base;

  assign gold = fa_golden(idx_q[2], idx_q[1], idx_q[0]);
  // Case inequality so an unknown response is judged a mismatch.
  assign mism = ({carry_in, sum_in} !== gold);

  // Results of the previous run survive until vector 0 of the next run is judged.
  assign fail_base = (idx_q == 3'd0) ? 8'h00 : fail_q;
  assign err_base  = (idx_q == 3'd0) ? 4'd0  : err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = 3'd0;
          fail_d  = 8'h00;
          err_d   = 4'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_DRIVE: begin
        abc_d   = idx_q;
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        fail_d = fail_base | (8'(mism) << idx_q);
        err_d  = err_base + 4'(mism);
        if (idx_q == 3'd0) begin
          pass_d = 1'b0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (err_q == 4'd0);
        if (CONTINUOUS) begin
          // Vector 0 is driven here so back-to-back runs repeat every 8*(SETTLE_CYCLES+2) cycles.
          idx_d   = 3'd0;
          abc_d   = 3'd0;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      abc_q   <= 3'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 8'h00;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign {a_out, b_out, c_out} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign err_count = err_q;

endmodule
